// File: rtl/satatrn_rxfisdemux_pkg.sv
// Shared definitions for the receive-side FIS demultiplexer:
//   FIS type codes seen in i_data[31:24] of a FIS's first word, and the
//   input FSM state encoding.
package satatrn_rxfisdemux_pkg;

  localparam logic [7:0] FIS_DATA     = 8'h46;
  localparam logic [7:0] FIS_D2H      = 8'h34;
  localparam logic [7:0] FIS_SDB      = 8'ha1;
  localparam logic [7:0] FIS_DMASETUP = 8'h41;
  localparam logic [7:0] FIS_PIOSETUP = 8'h5f;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REG  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

endpackage

// File: rtl/satatrn_rxfisdemux_pktfifo.sv
// sata_pktfifo: commit/rollback FIFO for whole register FISes.
//   i_wr/i_wdata  write a word at the uncommitted write pointer
//   i_commit      publish everything written so far (including a same-cycle write)
//   i_rollback    discard uncommitted words (write pointer <= commit pointer)
//   i_rd          pop the head when o_valid
//   o_valid       committed data present; o_rdata is the head (fall-through)
//   o_space       free words measured against the uncommitted write pointer
//   o_cspace      free words measured against the commit pointer
module sata_pktfifo #(
  parameter int WIDTH  = 33,
  parameter int LGFIFO = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_commit,
  input  logic              i_rollback,
  input  logic              i_rd,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_rdata,
  output logic [LGFIFO:0]   o_space,
  output logic [LGFIFO:0]   o_cspace
);
  localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};

  logic [WIDTH-1:0] r_mem [0:(1<<LGFIFO)-1];
  logic [LGFIFO:0]  r_wr, r_commit, r_rd;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr     <= '0;
      r_commit <= '0;
      r_rd     <= '0;
    end else begin
      if (i_rollback)  r_wr <= r_commit;
      else if (i_wr)   r_wr <= r_wr + {{LGFIFO{1'b0}}, 1'b1};
      // Commit covers the word being written in the same cycle.
      if (i_commit)    r_commit <= r_wr + {{LGFIFO{1'b0}}, i_wr};
      if (i_rd && o_valid) r_rd <= r_rd + {{LGFIFO{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk)
    if (i_wr) r_mem[r_wr[LGFIFO-1:0]] <= i_wdata;

  assign o_valid  = (r_rd != r_commit);
  assign o_rdata  = r_mem[r_rd[LGFIFO-1:0]];
  assign o_space  = DEPTH - (r_wr - r_rd);
  assign o_cspace = DEPTH - (r_commit - r_rd);

endmodule

// File: rtl/satatrn_rxfisdemux.sv
// satatrn_rxfisdemux: splits the link-layer FIS stream into a DATA path
// (1-cycle registered pass-through) and a register path (whole FISes held in
// a commit/rollback FIFO until their last word arrives).
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_link_err                kills the FIS in flight
//   i_valid/i_data/i_last     input word stream, no backpressure
//   o_hold                    committed free space < MAXREGW
//   o_reg_valid/i_reg_ready/o_reg_data/o_reg_last   register-FIS stream
//   o_data_valid/o_data_data/o_data_last/o_data_abort DATA-FIS stream
//   o_err_overlen/o_err_overflow  register FIS dropped (too long / no space)
module satatrn_rxfisdemux
  import satatrn_rxfisdemux_pkg::*;
#(
  parameter int         LGFIFO       = 5,
  parameter int         MAXREGW      = 7,
  parameter logic [7:0] DATA_FIS     = FIS_DATA,
  parameter bit         OPT_LOWPOWER = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_link_err,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_hold,
  output logic        o_reg_valid,
  input  logic        i_reg_ready,
  output logic [31:0] o_reg_data,
  output logic        o_reg_last,
  output logic        o_data_valid,
  output logic [31:0] o_data_data,
  output logic        o_data_last,
  output logic        o_data_abort,
  output logic        o_err_overlen,
  output logic        o_err_overflow
);
  localparam int              CW   = $clog2(MAXREGW + 1);
  localparam logic [CW-1:0]   MAXC = CW'(MAXREGW);
  localparam logic [LGFIFO:0] MAXS = (LGFIFO+1)'(MAXREGW);

  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic            w_route, w_wr, w_commit, w_rollback, w_ovf, w_olen;
  logic            w_fvalid;
  logic [32:0]     w_rdata;
  logic [LGFIFO:0] w_space, w_cspace;

  // Per-word routing decision; a link error discards the same-cycle word.
  always_comb begin
    w_route    = 1'b0;
    w_wr       = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    w_ovf      = 1'b0;
    w_olen     = 1'b0;
    if (i_link_err) begin
      w_rollback = (r_state == ST_REG);
    end else if (i_valid) begin
      case (r_state)
        ST_IDLE:
          if (i_data[31:24] == DATA_FIS) w_route = 1'b1;
          else if (w_space >= MAXS) begin
            w_wr     = 1'b1;
            w_commit = i_last;
          end else w_ovf = 1'b1;
        ST_REG:
          if (r_cnt == MAXC) begin
            w_rollback = 1'b1;
            w_olen     = 1'b1;
          end else begin
            w_wr     = 1'b1;
            w_commit = i_last;
          end
        ST_DATA: w_route = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      o_hold         <= 1'b0;
      o_data_valid   <= 1'b0;
      o_data_data    <= '0;
      o_data_last    <= 1'b0;
      o_data_abort   <= 1'b0;
      o_err_overlen  <= 1'b0;
      o_err_overflow <= 1'b0;
    end else begin
      o_hold         <= (w_cspace < MAXS);
      o_data_valid   <= w_route;
      o_data_abort   <= i_link_err && (r_state == ST_DATA);
      o_err_overlen  <= w_olen;
      o_err_overflow <= w_ovf;
      if (w_route) begin
        o_data_data <= i_data;
        o_data_last <= i_last;
      end else if (OPT_LOWPOWER) begin
        o_data_data <= '0;
        o_data_last <= 1'b0;
      end

      if (i_link_err) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (i_valid) begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= CW'(1);
            if (i_last)        r_state <= ST_IDLE;
            else if (w_route)  r_state <= ST_DATA;
            else if (w_wr)     r_state <= ST_REG;
            else               r_state <= ST_DROP;
          end
          ST_REG:
            if (w_olen)      r_state <= i_last ? ST_IDLE : ST_DROP;
            else begin
              r_cnt <= r_cnt + CW'(1);
              if (i_last) r_state <= ST_IDLE;
            end
          default:
            if (i_last) r_state <= ST_IDLE;
        endcase
      end
    end
  end

  sata_pktfifo #(.WIDTH(33), .LGFIFO(LGFIFO)) u_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr       (w_wr),
    .i_wdata    ({i_last, i_data}),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_rd       (i_reg_ready),
    .o_valid    (w_fvalid),
    .o_rdata    (w_rdata),
    .o_space    (w_space),
    .o_cspace   (w_cspace)
  );

  // Head is masked while empty so the register path reads as all-zero idle.
  assign o_reg_valid = w_fvalid;
  assign o_reg_data  = w_fvalid ? w_rdata[31:0] : 32'h0;
  assign o_reg_last  = w_fvalid & w_rdata[32];

endmodule
